// File: rtl/multicycle_ctrl_fsm_if.sv
// Handshake bundle between the multi-cycle sequencer and its
// instruction/memory environment (master = environment).
interface multicycle_ctrl_fsm_if #(
  parameter int CODE_W = 6
);
  logic              start;
  logic [CODE_W-1:0] op_code;
  logic [CODE_W-1:0] func_code;
  logic              mem_ready;
  logic              err_clr;
  logic              alu_sel;
  logic [CODE_W-1:0] alu_code;
  logic              mem_read;
  logic              mem_write;
  logic              ir_write;
  logic              pc_write;
  logic              branch_en;
  logic              reg_write;
  logic              reg_dst;
  logic              busy;
  logic              done;
  logic [1:0]        err_cause;

  modport master (
    output start,
    output op_code,
    output func_code,
    output mem_ready,
    output err_clr,
    input  alu_sel,
    input  alu_code,
    input  mem_read,
    input  mem_write,
    input  ir_write,
    input  pc_write,
    input  branch_en,
    input  reg_write,
    input  reg_dst,
    input  busy,
    input  done,
    input  err_cause
  );

  modport slave (
    input  start,
    input  op_code,
    input  func_code,
    input  mem_ready,
    input  err_clr,
    output alu_sel,
    output alu_code,
    output mem_read,
    output mem_write,
    output ir_write,
    output pc_write,
    output branch_en,
    output reg_write,
    output reg_dst,
    output busy,
    output done,
    output err_cause
  );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS-subset control sequencer (FETCH..WB, mem timeout).
// Optional: ILLEGAL_OP_TRAP_EN sends illegal opcodes to ERR.
module multicycle_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CODE_W      = 6
) (
  input logic                  clk,
  input logic                  reset,
  multicycle_ctrl_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    ERR    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_LW,
    CL_SW,
    CL_ADDI,
    CL_BEQ,
    CL_J,
    CL_ILL
  } cls_t;

  localparam logic [CODE_W-1:0] OP_R    = CODE_W'(6'b000000);
  localparam logic [CODE_W-1:0] OP_LW   = CODE_W'(6'b100011);
  localparam logic [CODE_W-1:0] OP_SW   = CODE_W'(6'b101011);
  localparam logic [CODE_W-1:0] OP_ADDI = CODE_W'(6'b001000);
  localparam logic [CODE_W-1:0] OP_BEQ  = CODE_W'(6'b000100);
  localparam logic [CODE_W-1:0] OP_J    = CODE_W'(6'b000010);

  localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT);

  localparam logic [1:0] E_NONE = 2'b00;
  localparam logic [1:0] E_TMO  = 2'b01;
`ifdef ILLEGAL_OP_TRAP_EN
  localparam logic [1:0] E_ILL  = 2'b10;
`endif

  state_t            state_q, state_d;
  cls_t              cls_q, cls_d, dec_cls;
  logic              alu_sel_q, alu_sel_d;
  logic [CODE_W-1:0] alu_code_q, alu_code_d;
  logic [7:0]        wait_q, wait_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic rd, wr, irw, pcw, br, rw, rdst;
  logic timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cls_q      <= CL_R;
      alu_sel_q  <= 1'b0;
      alu_code_q <= '0;
      wait_q     <= 8'd0;
      done_q     <= 1'b0;
      err_q      <= E_NONE;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      alu_sel_q  <= alu_sel_d;
      alu_code_q <= alu_code_d;
      wait_q     <= wait_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    dec_cls = CL_ILL;
    unique case (1'b1)
      bus.op_code == OP_R:    dec_cls = CL_R;
      bus.op_code == OP_LW:   dec_cls = CL_LW;
      bus.op_code == OP_SW:   dec_cls = CL_SW;
      bus.op_code == OP_ADDI: dec_cls = CL_ADDI;
      bus.op_code == OP_BEQ:  dec_cls = CL_BEQ;
      bus.op_code == OP_J:    dec_cls = CL_J;
      default:                dec_cls = CL_ILL;
    endcase
  end

  // a ready arriving on the limit cycle still completes the access
  assign timeout = (wait_q == LIMIT) & ~bus.mem_ready;

  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    alu_sel_d  = alu_sel_q;
    alu_code_d = alu_code_q;
    wait_d     = wait_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rd         = 1'b0;
    wr         = 1'b0;
    irw        = 1'b0;
    pcw        = 1'b0;
    br         = 1'b0;
    rw         = 1'b0;
    rdst       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = FETCH;
          wait_d  = 8'd0;
        end
      end
      FETCH: begin
        rd = 1'b1;
        if (bus.mem_ready) begin
          irw     = 1'b1;
          pcw     = 1'b1;
          state_d = DECODE;
        end else if (timeout) begin
          state_d = ERR;
          err_d   = E_TMO;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      DECODE: begin
        alu_sel_d  = (bus.op_code != '0);
        alu_code_d = alu_sel_d ? bus.op_code
                               : bus.func_code;
        cls_d      = dec_cls;
        state_d    = EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
        if (dec_cls == CL_ILL) begin
          state_d = ERR;
          err_d   = E_ILL;
        end
`endif
      end
      EXEC: begin
        unique case (cls_q)
          CL_R, CL_ADDI: state_d = WB;
          CL_LW, CL_SW: begin
            state_d = MEM;
            wait_d  = 8'd0;
          end
          CL_BEQ: begin
            br      = 1'b1;
            state_d = IDLE;
            done_d  = 1'b1;
          end
          CL_J: begin
            pcw     = 1'b1;
            state_d = IDLE;
            done_d  = 1'b1;
          end
          default: begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        endcase
      end
      MEM: begin
        rd = (cls_q == CL_LW);
        wr = (cls_q != CL_LW);
        if (bus.mem_ready) begin
          if (cls_q == CL_LW) begin
            state_d = WB;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (timeout) begin
          state_d = ERR;
          err_d   = E_TMO;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      WB: begin
        rw      = 1'b1;
        rdst    = (cls_q == CL_R);
        state_d = IDLE;
        done_d  = 1'b1;
      end
      ERR: begin
        if (bus.err_clr) begin
          state_d = IDLE;
          err_d   = E_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // strobes are silenced in the cycle reset aborts an instruction
  assign bus.mem_read  = rd   & ~reset;
  assign bus.mem_write = wr   & ~reset;
  assign bus.ir_write  = irw  & ~reset;
  assign bus.pc_write  = pcw  & ~reset;
  assign bus.branch_en = br   & ~reset;
  assign bus.reg_write = rw   & ~reset;
  assign bus.reg_dst   = rdst & ~reset;

  assign bus.alu_sel   = alu_sel_q;
  assign bus.alu_code  = alu_code_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err_cause = err_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboard bench for multicycle_ctrl_fsm: directed instructions,
// memory responder with per-access delays, monitor checks retirements.
module tb_multicycle_ctrl_fsm;

  logic clk;
  logic reset;

  multicycle_ctrl_fsm_if #(.CODE_W(6)) dut_if ();

  multicycle_ctrl_fsm #(
    .MEM_TIMEOUT(15),
    .CODE_W(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(dut_if)
  );

  typedef struct {
    string      tag;
    bit         is_err;
    logic [1:0] cause;
    int         lat;
    bit         chk_alu;
    logic       sel;
    logic [5:0] code;
    int         n_rd;
    int         n_wr;
    int         n_ir;
    int         n_pc;
    int         n_br;
    int         n_rw;
    logic       rdst;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   fetch_dly = 0;
  int   mem_dly = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(
    input string tag, input bit is_err, input logic [1:0] cause,
    input int lat, input bit chk_alu, input logic sel,
    input logic [5:0] code, input int rd, input int wr,
    input int ir, input int pc, input int br, input int rw,
    input logic rdst);
    exp_t e;
    e.tag = tag; e.is_err = is_err; e.cause = cause;
    e.lat = lat; e.chk_alu = chk_alu; e.sel = sel;
    e.code = code; e.n_rd = rd; e.n_wr = wr; e.n_ir = ir;
    e.n_pc = pc; e.n_br = br; e.n_rw = rw; e.rdst = rdst;
    return e;
  endfunction

  // memory model: the n-th cycle of an access (0-based) returns ready
  initial begin : responder
    int acc;
    int idx;
    acc = 0;
    idx = 0;
    dut_if.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (dut_if.mem_read || dut_if.mem_write) begin
        if (acc == (idx == 0 ? fetch_dly : mem_dly)) begin
          dut_if.mem_ready = 1'b1;
          idx++;
          acc = 0;
        end else begin
          dut_if.mem_ready = 1'b0;
          acc++;
        end
      end else begin
        dut_if.mem_ready = 1'b0;
        acc = 0;
      end
      if (!dut_if.busy) idx = 0;
    end
  end

  initial begin : monitor
    bit   active;
    int   cyc, n_rd, n_wr, n_ir, n_pc, n_br, n_rw;
    logic rdst_seen;
    exp_t e;
    active = 0;
    cyc = 0; n_rd = 0; n_wr = 0; n_ir = 0;
    n_pc = 0; n_br = 0; n_rw = 0; rdst_seen = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        active = 0;
      end else begin
        if (active) begin
          cyc++;
          n_rd += int'(dut_if.mem_read);
          n_wr += int'(dut_if.mem_write);
          n_ir += int'(dut_if.ir_write);
          n_pc += int'(dut_if.pc_write);
          n_br += int'(dut_if.branch_en);
          n_rw += int'(dut_if.reg_write);
          if (dut_if.reg_write) rdst_seen = dut_if.reg_dst;
          if (dut_if.done || dut_if.err_cause != 2'b00) begin
            active = 0;
            if (sb.size() == 0) begin
              chk("unexpected_event", 1, 0);
            end else begin
              e = sb.pop_front();
              chk({e.tag, ".is_err"},
                  int'(dut_if.err_cause != 2'b00), int'(e.is_err));
              chk({e.tag, ".err_cause"},
                  int'(dut_if.err_cause), int'(e.cause));
              chk({e.tag, ".latency"}, cyc, e.lat);
              if (e.chk_alu) begin
                chk({e.tag, ".alu_sel"},
                    int'(dut_if.alu_sel), int'(e.sel));
                chk({e.tag, ".alu_code"},
                    int'(dut_if.alu_code), int'(e.code));
              end
              chk({e.tag, ".mem_read_cyc"}, n_rd, e.n_rd);
              chk({e.tag, ".mem_write_cyc"}, n_wr, e.n_wr);
              chk({e.tag, ".ir_write_cyc"}, n_ir, e.n_ir);
              chk({e.tag, ".pc_write_cyc"}, n_pc, e.n_pc);
              chk({e.tag, ".branch_cyc"}, n_br, e.n_br);
              chk({e.tag, ".reg_write_cyc"}, n_rw, e.n_rw);
              if (e.n_rw != 0)
                chk({e.tag, ".reg_dst"},
                    int'(rdst_seen), int'(e.rdst));
            end
          end
        end else if (dut_if.done) begin
          chk("unexpected_done", 1, 0);
        end
        if (!active && dut_if.start && !dut_if.busy) begin
          active = 1;
          cyc = 0; n_rd = 0; n_wr = 0; n_ir = 0;
          n_pc = 0; n_br = 0; n_rw = 0; rdst_seen = 1'b0;
        end
      end
    end
  end

  task automatic run(
    input exp_t e, input logic [5:0] op, input logic [5:0] fn,
    input int f, input int m, input int poke, input bit clr);
    int n;
    fetch_dly = f;
    mem_dly   = m;
    sb.push_back(e);
    @(posedge clk); #1;
    dut_if.op_code   = op;
    dut_if.func_code = fn;
    dut_if.start     = 1'b1;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    if (poke > 0) begin
      repeat (poke) @(posedge clk);
      #1 dut_if.start = 1'b1;
      @(posedge clk); #1;
      dut_if.start = 1'b0;
    end
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    chk({e.tag, ".retired_in_time"}, int'(sb.size() == 0), 1);
    if (sb.size() != 0) sb.delete();
    if (clr) begin
      #1 dut_if.start = 1'b1;
      @(posedge clk); #1;
      dut_if.start = 1'b0;
      chk({e.tag, ".err_busy"}, int'(dut_if.busy), 1);
      chk({e.tag, ".err_hold"}, int'(dut_if.err_cause), int'(e.cause));
      dut_if.err_clr = 1'b1;
      @(posedge clk); #1;
      dut_if.err_clr = 1'b0;
      chk({e.tag, ".clr_idle"}, int'(dut_if.busy), 0);
      chk({e.tag, ".clr_cause"}, int'(dut_if.err_cause), 0);
    end
  endtask

  initial begin : stim
    int n;
    reset            = 1'b1;
    dut_if.start     = 1'b0;
    dut_if.op_code   = 6'd0;
    dut_if.func_code = 6'd0;
    dut_if.err_clr   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", int'(dut_if.busy), 0);
    chk("rst.done", int'(dut_if.done), 0);
    chk("rst.alu_sel", int'(dut_if.alu_sel), 0);
    chk("rst.alu_code", int'(dut_if.alu_code), 0);
    chk("rst.err_cause", int'(dut_if.err_cause), 0);
    chk("rst.mem_read", int'(dut_if.mem_read), 0);
    chk("rst.pc_write", int'(dut_if.pc_write), 0);
    chk("rst.reg_write", int'(dut_if.reg_write), 0);
    reset = 1'b0;

    run(mk("r_add", 0, 2'b00, 5, 1, 0, 6'b100000,
           1, 0, 1, 1, 0, 1, 1),
        6'b000000, 6'b100000, 0, 0, 0, 0);
    run(mk("lw", 0, 2'b00, 9, 1, 1, 6'b100011,
           5, 0, 1, 1, 0, 1, 0),
        6'b100011, 6'b000000, 0, 3, 2, 0);
    run(mk("beq", 0, 2'b00, 4, 1, 1, 6'b000100,
           1, 0, 1, 1, 1, 0, 0),
        6'b000100, 6'b100101, 0, 0, 0, 0);
    run(mk("sw", 0, 2'b00, 8, 1, 1, 6'b101011,
           2, 3, 1, 1, 0, 0, 0),
        6'b101011, 6'b000111, 1, 2, 0, 0);
    run(mk("addi", 0, 2'b00, 7, 1, 1, 6'b001000,
           3, 0, 1, 1, 0, 1, 0),
        6'b001000, 6'b000001, 2, 0, 0, 0);
    run(mk("j", 0, 2'b00, 4, 1, 1, 6'b000010,
           1, 0, 1, 2, 0, 0, 0),
        6'b000010, 6'b010101, 0, 0, 0, 0);
    run(mk("r_slt", 0, 2'b00, 5, 1, 0, 6'b101010,
           1, 0, 1, 1, 0, 1, 1),
        6'b000000, 6'b101010, 0, 0, 0, 0);
`ifdef ILLEGAL_OP_TRAP_EN
    run(mk("illegal", 1, 2'b10, 3, 1, 1, 6'b111111,
           1, 0, 1, 1, 0, 0, 0),
        6'b111111, 6'b000001, 0, 0, 0, 1);
`else
    run(mk("illegal", 0, 2'b00, 4, 1, 1, 6'b111111,
           1, 0, 1, 1, 0, 0, 0),
        6'b111111, 6'b000001, 0, 0, 0, 0);
`endif
    run(mk("fetch_tmo", 1, 2'b01, 17, 0, 0, 6'b000000,
           16, 0, 0, 0, 0, 0, 0),
        6'b000000, 6'b100000, 100, 0, 0, 1);
    run(mk("fetch_edge", 0, 2'b00, 20, 1, 0, 6'b100000,
           16, 0, 1, 1, 0, 1, 1),
        6'b000000, 6'b100000, 15, 0, 0, 0);
    run(mk("mem_tmo", 1, 2'b01, 20, 1, 1, 6'b100011,
           17, 0, 1, 1, 0, 0, 0),
        6'b100011, 6'b000000, 0, 100, 0, 1);

    // sw aborted by reset while stalled in MEM
    fetch_dly = 0;
    mem_dly   = 100;
    @(posedge clk); #1;
    dut_if.op_code   = 6'b101011;
    dut_if.func_code = 6'b000000;
    dut_if.start     = 1'b1;
    @(posedge clk); #1;
    dut_if.start = 1'b0;
    n = 0;
    while (!dut_if.mem_write && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("sw_abort.reached_mem", int'(dut_if.mem_write), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("sw_abort.rst_cyc_mem_write", int'(dut_if.mem_write), 0);
    chk("sw_abort.rst_cyc_done", int'(dut_if.done), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    chk("sw_abort.idle", int'(dut_if.busy), 0);
    chk("sw_abort.mem_write", int'(dut_if.mem_write), 0);
    chk("sw_abort.alu_sel", int'(dut_if.alu_sel), 0);
    repeat (4) @(posedge clk);

    run(mk("r_after_rst", 0, 2'b00, 5, 1, 0, 6'b100100,
           1, 0, 1, 1, 0, 1, 1),
        6'b000000, 6'b100100, 0, 0, 0, 0);

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
